// File: rtl/vector_writeback_stage.sv
// ============================================================================
// vector_writeback_stage
// ----------------------------------------------------------------------------
// Final pipeline stage of the vector processor, directly downstream of the
// memory stage. It picks the result to retire from the memory-stage bundle,
// buffers it in a 2-entry skid FIFO, and drives either the vector or the
// scalar register-file write port from the FIFO head under a ready handshake.
// The FIFO head is also exported as a forwarding source for the execute stage.
//
// Optional feature:
//   VEC_WB_RETIRE_CNT_EN  when defined, retired_cnt counts committed writes
//                         (32-bit, wrapping, reset to 0, unaffected by flush).
//                         When undefined, retired_cnt is tied to 0 and no
//                         counter flops exist.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   valid_m         memory-stage bundle valid
//   ready_m         stage can accept a bundle this cycle (registered count only)
//   wb_m            writeback select: 0 addervv, 1 scalar ALU, 2 vector ALU,
//                   3 memory data
//   addervv_m       vector adder result
//   resALUe_m       scalar ALU result
//   resALUve_m      vector ALU result
//   memData_m       memory load data
//   dest_m          destination register index
//   flush           synchronous squash of all buffered entries
//   rf_ready        register file accepts the write this cycle
//   vwe, swe        vector / scalar write requests
//   waddr           write address
//   vwdata, swdata  vector / scalar write data
//   fwd_valid       FIFO head is valid
//   fwd_vec         FIFO head targets the vector file
//   fwd_dest        FIFO head destination
//   fwd_data        FIFO head data (scalar entries zero-extended)
//   retired_cnt     committed-write counter (see optional feature)
// ============================================================================

module vector_writeback_stage #(
    parameter int VEC_W  = 192,
    parameter int SCL_W  = 21,
    parameter int DEST_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              valid_m,
    output logic              ready_m,
    input  logic [1:0]        wb_m,
    input  logic [VEC_W-1:0]  addervv_m,
    input  logic [SCL_W-1:0]  resALUe_m,
    input  logic [VEC_W-1:0]  resALUve_m,
    input  logic [VEC_W-1:0]  memData_m,
    input  logic [DEST_W-1:0] dest_m,

    input  logic              flush,
    input  logic              rf_ready,

    output logic              vwe,
    output logic              swe,
    output logic [DEST_W-1:0] waddr,
    output logic [VEC_W-1:0]  vwdata,
    output logic [SCL_W-1:0]  swdata,

    output logic              fwd_valid,
    output logic              fwd_vec,
    output logic [DEST_W-1:0] fwd_dest,
    output logic [VEC_W-1:0]  fwd_data,

    output logic [31:0]       retired_cnt
);

    // ------------------------------------------------------------------------
    // Occupancy states (the FIFO count doubles as the state encoding)
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'(DEPTH);

    // Writeback select encodings
    localparam logic [1:0] WB_ADDERVV = 2'd0;
    localparam logic [1:0] WB_SCALAR  = 2'd1;
    localparam logic [1:0] WB_VALU    = 2'd2;
    localparam logic [1:0] WB_MEM     = 2'd3;

    // ------------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------------
    logic [1:0]        count;
    logic [1:0]        count_nxt;
    logic              wr_ptr;
    logic              rd_ptr;

    logic              entry_vec  [DEPTH];
    logic [DEST_W-1:0] entry_dest [DEPTH];
    logic [VEC_W-1:0]  entry_data [DEPTH];

    logic              head_valid;
    logic              push;
    logic              commit;

    // ------------------------------------------------------------------------
    // Entry capture: result selection from the memory-stage bundle
    // ------------------------------------------------------------------------
    logic              cap_vec;
    logic [VEC_W-1:0]  cap_data;

    // NOTE: every signal written in always_comb is given a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        cap_data = '0;
        case (wb_m)
            WB_ADDERVV: cap_data = addervv_m;
            WB_SCALAR:  cap_data = VEC_W'(resALUe_m);
            WB_VALU:    cap_data = resALUve_m;
            WB_MEM:     cap_data = memData_m;
            default:    cap_data = '0;
        endcase
    end

    assign cap_vec = (wb_m != WB_SCALAR);

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    // ready_m looks only at the registered count (and reset), never at
    // rf_ready, so a full FIFO refuses a bundle even when it pops that cycle.
    assign ready_m    = rst_n && (count != ST_FULL);
    assign head_valid = (count != ST_EMPTY);

    // Flush beats both push and pop: nothing is captured or committed.
    assign push   = valid_m && ready_m && !flush;
    assign commit = head_valid && rf_ready && !flush;

    always_comb begin
        count_nxt = count;
        case ({push, commit})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= ST_EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (flush) begin
            count  <= ST_EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            count <= count_nxt;
            // One-bit pointers wrap 1 -> 0 naturally.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (commit) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------------
    // NOTE: the entry array is deliberately left without a reset; an entry is
    // only ever observed while count says it is occupied, and every output is
    // gated by head_valid, so stale contents never leak out.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_vec[wr_ptr]  <= cap_vec;
            entry_dest[wr_ptr] <= dest_m;
            entry_data[wr_ptr] <= cap_data;
        end
    end

    // ------------------------------------------------------------------------
    // Head drive: register-file write port and forwarding tap
    // ------------------------------------------------------------------------
    always_comb begin
        vwe       = 1'b0;
        swe       = 1'b0;
        waddr     = '0;
        vwdata    = '0;
        swdata    = '0;
        fwd_valid = 1'b0;
        fwd_vec   = 1'b0;
        fwd_dest  = '0;
        fwd_data  = '0;
        if (head_valid) begin
            vwe       = entry_vec[rd_ptr];
            swe       = !entry_vec[rd_ptr];
            waddr     = entry_dest[rd_ptr];
            vwdata    = entry_data[rd_ptr];
            swdata    = entry_data[rd_ptr][SCL_W-1:0];
            fwd_valid = 1'b1;
            fwd_vec   = entry_vec[rd_ptr];
            fwd_dest  = entry_dest[rd_ptr];
            fwd_data  = entry_data[rd_ptr];
        end
    end

    // ------------------------------------------------------------------------
    // Retired-write counter
    // ------------------------------------------------------------------------
`ifdef VEC_WB_RETIRE_CNT_EN
    logic [31:0] retire_q;

    // Counts commits only; flush suppresses commit, so it never counts here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_q <= '0;
        end else if (commit) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign retired_cnt = retire_q;
`else
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_vector_writeback_stage.sv
// ============================================================================
// tb_vector_writeback_stage
// ----------------------------------------------------------------------------
// Self-checking bench for vector_writeback_stage: hand-written sequences for
// the multi-cycle corner cases plus a table of directed per-cycle vectors.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// ============================================================================

module tb_vector_writeback_stage;

    localparam int VEC_W  = 192;
    localparam int SCL_W  = 21;
    localparam int DEST_W = 3;

`ifdef VEC_WB_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              valid_m;
    logic              ready_m;
    logic [1:0]        wb_m;
    logic [VEC_W-1:0]  addervv_m;
    logic [SCL_W-1:0]  resALUe_m;
    logic [VEC_W-1:0]  resALUve_m;
    logic [VEC_W-1:0]  memData_m;
    logic [DEST_W-1:0] dest_m;
    logic              flush;
    logic              rf_ready;
    logic              vwe;
    logic              swe;
    logic [DEST_W-1:0] waddr;
    logic [VEC_W-1:0]  vwdata;
    logic [SCL_W-1:0]  swdata;
    logic              fwd_valid;
    logic              fwd_vec;
    logic [DEST_W-1:0] fwd_dest;
    logic [VEC_W-1:0]  fwd_data;
    logic [31:0]       retired_cnt;

    int n_pass  = 0;
    int n_total = 0;

    vector_writeback_stage #(
        .VEC_W (VEC_W),
        .SCL_W (SCL_W),
        .DEST_W(DEST_W),
        .DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_m    (valid_m),
        .ready_m    (ready_m),
        .wb_m       (wb_m),
        .addervv_m  (addervv_m),
        .resALUe_m  (resALUe_m),
        .resALUve_m (resALUve_m),
        .memData_m  (memData_m),
        .dest_m     (dest_m),
        .flush      (flush),
        .rf_ready   (rf_ready),
        .vwe        (vwe),
        .swe        (swe),
        .waddr      (waddr),
        .vwdata     (vwdata),
        .swdata     (swdata),
        .fwd_valid  (fwd_valid),
        .fwd_vec    (fwd_vec),
        .fwd_dest   (fwd_dest),
        .fwd_data   (fwd_data),
        .retired_cnt(retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic check(input string name, input logic [VEC_W-1:0] act,
                         input logic [VEC_W-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the whole write port / forwarding tap against one expected head.
    task automatic check_head(input string tag, input logic e_ready,
                              input logic e_vwe, input logic e_swe,
                              input logic [DEST_W-1:0] e_waddr,
                              input logic [VEC_W-1:0] e_data,
                              input logic e_fv);
        check({tag, ".ready_m"},   VEC_W'(ready_m),   VEC_W'(e_ready));
        check({tag, ".vwe"},       VEC_W'(vwe),       VEC_W'(e_vwe));
        check({tag, ".swe"},       VEC_W'(swe),       VEC_W'(e_swe));
        check({tag, ".waddr"},     VEC_W'(waddr),     VEC_W'(e_waddr));
        check({tag, ".vwdata"},    vwdata,            e_data);
        check({tag, ".swdata"},    VEC_W'(swdata),    VEC_W'(e_data[SCL_W-1:0]));
        check({tag, ".fwd_valid"}, VEC_W'(fwd_valid), VEC_W'(e_fv));
        check({tag, ".fwd_vec"},   VEC_W'(fwd_vec),   VEC_W'(e_vwe));
        check({tag, ".fwd_dest"},  VEC_W'(fwd_dest),  VEC_W'(e_waddr));
        check({tag, ".fwd_data"},  fwd_data,          e_data);
    endtask

    task automatic check_cnt(input string tag, input int commits);
        check({tag, ".retired_cnt"}, VEC_W'(retired_cnt),
              CNT_EN ? VEC_W'(commits) : '0);
    endtask

    task automatic idle_inputs();
        valid_m    = 1'b0;
        wb_m       = 2'd0;
        addervv_m  = '0;
        resALUe_m  = '0;
        resALUve_m = '0;
        memData_m  = '0;
        dest_m     = '0;
        flush      = 1'b0;
        rf_ready   = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Table of per-cycle vectors. Row i drives add=0x100+i, salu=0x200+i,
    // valu=0x300+i, mem=0x400+i; expectations describe the head after the edge.
    // ------------------------------------------------------------------------
    typedef struct {
        logic              valid;
        logic [1:0]        wb;
        logic [DEST_W-1:0] dest;
        logic              rf;
        logic              fl;
        logic              e_ready;
        logic              e_vwe;
        logic              e_swe;
        logic [DEST_W-1:0] e_waddr;
        logic [VEC_W-1:0]  e_data;
        logic              e_fv;
    } vec_t;

    function automatic vec_t mk(logic valid, logic [1:0] wb, logic [DEST_W-1:0] dest,
                                logic rf, logic fl, logic e_ready, logic e_vwe,
                                logic e_swe, logic [DEST_W-1:0] e_waddr,
                                logic [31:0] e_data, logic e_fv);
        vec_t v;
        v.valid   = valid;   v.wb      = wb;     v.dest  = dest;
        v.rf      = rf;      v.fl      = fl;     v.e_ready = e_ready;
        v.e_vwe   = e_vwe;   v.e_swe   = e_swe;  v.e_waddr = e_waddr;
        v.e_data  = VEC_W'(e_data);
        v.e_fv    = e_fv;
        return v;
    endfunction

    vec_t tbl [10];
    int   commits;

    initial begin
        //          vld wb  dst rf fl  rdy vwe swe wad data      fv
        tbl[0] = mk(1, 2'd0, 1, 0, 0,  1,  1,  0,  1, 32'h100,  1); // push vec
        tbl[1] = mk(1, 2'd1, 2, 0, 0,  0,  1,  0,  1, 32'h100,  1); // fill, full
        tbl[2] = mk(1, 2'd3, 3, 1, 0,  1,  0,  1,  2, 32'h201,  1); // full: no push, pop
        tbl[3] = mk(1, 2'd3, 3, 1, 0,  1,  1,  0,  3, 32'h403,  1); // push+pop
        tbl[4] = mk(1, 2'd2, 4, 1, 0,  1,  1,  0,  4, 32'h304,  1); // push+pop
        tbl[5] = mk(0, 2'd0, 0, 1, 0,  1,  0,  0,  0, 32'h0,    0); // drain
        tbl[6] = mk(1, 2'd0, 7, 1, 0,  1,  1,  0,  7, 32'h106,  1); // push into empty
        tbl[7] = mk(1, 2'd1, 0, 0, 0,  0,  1,  0,  7, 32'h106,  1); // fill, full
        tbl[8] = mk(1, 2'd2, 5, 1, 1,  1,  0,  0,  0, 32'h0,    0); // flush wins
        tbl[9] = mk(0, 2'd0, 0, 1, 0,  1,  0,  0,  0, 32'h0,    0); // stays empty

        idle_inputs();
        commits = 0;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        #1;
        check_head("reset", 0, 0, 0, 0, '0, 0);
        check_cnt("reset", 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("post_reset.ready_m", VEC_W'(ready_m), VEC_W'(1'b1));

        // ---------------- single vector bundle ----------------
        valid_m    = 1'b1;
        wb_m       = 2'd2;
        dest_m     = 3'd5;
        resALUve_m = {24{8'hA5}};
        rf_ready   = 1'b1;
        tick();
        check_head("single", 1, 1, 0, 5, {24{8'hA5}}, 1);
        valid_m = 1'b0;
        tick();
        commits += 1;
        check_head("single_after", 1, 0, 0, 0, '0, 0);
        check_cnt("single_after", commits);

        // ---------------- scalar path ----------------
        valid_m   = 1'b1;
        wb_m      = 2'd1;
        resALUe_m = 21'h1FFFFF;
        dest_m    = 3'd3;
        tick();
        check_head("scalar", 1, 0, 1, 3, 192'h1FFFFF, 1);
        valid_m = 1'b0;
        tick();
        commits += 1;
        check_head("scalar_after", 1, 0, 0, 0, '0, 0);

        // ---------------- flush at count=2 with valid_m ----------------
        rf_ready  = 1'b0;
        valid_m   = 1'b1;
        wb_m      = 2'd0;
        addervv_m = 192'h7;
        dest_m    = 3'd1;
        tick();
        addervv_m = 192'h8;
        dest_m    = 3'd2;
        tick();
        check_head("flush_full", 0, 1, 0, 1, 192'h7, 1);
        addervv_m = 192'h9;
        dest_m    = 3'd6;
        flush     = 1'b1;
        rf_ready  = 1'b1;
        tick();
        check_head("flush_edge", 1, 0, 0, 0, '0, 0);
        check_cnt("flush_edge", commits);
        flush   = 1'b0;
        valid_m = 1'b0;
        tick();
        check_head("flush_after", 1, 0, 0, 0, '0, 0);

        // ---------------- backpressure, memData 1,2,3 ----------------
        rf_ready  = 1'b0;
        valid_m   = 1'b1;
        wb_m      = 2'd3;
        memData_m = 192'd1;
        dest_m    = 3'd1;
        tick();
        check_head("bp_1", 1, 1, 0, 1, 192'd1, 1);
        memData_m = 192'd2;
        dest_m    = 3'd2;
        tick();
        check_head("bp_2", 0, 1, 0, 1, 192'd1, 1);
        memData_m = 192'd3;
        dest_m    = 3'd3;
        tick();
        check_head("bp_held", 0, 1, 0, 1, 192'd1, 1);
        rf_ready = 1'b1;
        tick();
        check_head("bp_wr2", 1, 1, 0, 2, 192'd2, 1);
        tick();
        check_head("bp_wr3", 1, 1, 0, 3, 192'd3, 1);
        valid_m = 1'b0;
        tick();
        commits += 3;
        check_head("bp_done", 1, 0, 0, 0, '0, 0);
        check_cnt("bp_done", commits);

        // ---------------- simultaneous push/pop at count=1 ----------------
        rf_ready   = 1'b0;
        valid_m    = 1'b1;
        wb_m       = 2'd2;
        resALUve_m = 192'd10;
        dest_m     = 3'd0;
        tick();
        check_head("pp_pre", 1, 1, 0, 0, 192'd10, 1);
        rf_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            resALUve_m = VEC_W'(10 + k);
            dest_m     = DEST_W'(k);
            tick();
            check_head($sformatf("pp_%0d", k), 1, 1, 0, DEST_W'(k), VEC_W'(10 + k), 1);
        end
        valid_m = 1'b0;
        tick();
        commits += 5;
        check_head("pp_done", 1, 0, 0, 0, '0, 0);
        check_cnt("pp_done", commits);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 10; i++) begin
            valid_m    = tbl[i].valid;
            wb_m       = tbl[i].wb;
            dest_m     = tbl[i].dest;
            rf_ready   = tbl[i].rf;
            flush      = tbl[i].fl;
            addervv_m  = VEC_W'(32'h100 + i);
            resALUe_m  = SCL_W'(32'h200 + i);
            resALUve_m = VEC_W'(32'h300 + i);
            memData_m  = VEC_W'(32'h400 + i);
            tick();
            check_head($sformatf("tbl_%0d", i), tbl[i].e_ready, tbl[i].e_vwe,
                       tbl[i].e_swe, tbl[i].e_waddr, tbl[i].e_data, tbl[i].e_fv);
        end
        flush = 1'b0;
        commits += 4;
        check_cnt("tbl_done", commits);

        // ---------------- async reset mid-drain ----------------
        rf_ready   = 1'b0;
        valid_m    = 1'b1;
        wb_m       = 2'd2;
        resALUve_m = 192'hBEEF;
        dest_m     = 3'd6;
        tick();
        dest_m = 3'd5;
        tick();
        check_head("ar_full", 0, 1, 0, 6, 192'hBEEF, 1);
        valid_m  = 1'b0;
        rf_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_head("ar_async", 0, 0, 0, 0, '0, 0);
        check_cnt("ar_async", 0);
        tick();
        rst_n = 1'b1;
        tick();
        check_head("ar_release", 1, 0, 0, 0, '0, 0);
        tick();
        check_head("ar_idle", 1, 0, 0, 0, '0, 0);
        valid_m   = 1'b1;
        wb_m      = 2'd0;
        addervv_m = 192'h55;
        dest_m    = 3'd2;
        tick();
        check_head("ar_push", 1, 1, 0, 2, 192'h55, 1);
        valid_m = 1'b0;
        tick();
        check_head("ar_done", 1, 0, 0, 0, '0, 0);
        check_cnt("ar_done", 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vector_writeback_stage.md
Name: vector_writeback_stage

Overview:
- Final pipeline stage, directly downstream of the vector processor's memory stage.
- Consumes the memory-stage bundle: writeback select, adder-vv result, scalar ALU result, vector ALU result, memory data and destination.
- Selects the result to retire and buffers it in a 2-entry skid FIFO, then drives the vector or scalar register-file write port under a ready handshake.
- The FIFO head is exported as a forwarding source for the execute stage.

Parameters:
- VEC_W, 192, vector datapath width (8 lanes x 24 bit).
- SCL_W, 21, scalar ALU result width.
- DEST_W, 3, register index width (8 registers per file).
- DEPTH, 2, skid FIFO entries; fixed at 2, other values unsupported.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_m  in  1  memory-stage bundle valid.
- ready_m  out  1  stage can accept a bundle this cycle.
- wb_m  in  2  writeback select: 0 addervv, 1 scalar ALU, 2 vector ALU, 3 memData.
- addervv_m  in  VEC_W  vector adder result.
- resALUe_m  in  SCL_W  scalar ALU result.
- resALUve_m  in  VEC_W  vector ALU result.
- memData_m  in  VEC_W  memory load data.
- dest_m  in  DEST_W  destination register.
- flush  in  1  synchronous squash of all buffered entries.
- rf_ready  in  1  register file accepts the write this cycle.
- vwe  out  1  vector write request.
- swe  out  1  scalar write request.
- waddr  out  DEST_W  write address.
- vwdata  out  VEC_W  vector write data.
- swdata  out  SCL_W  scalar write data.
- fwd_valid  out  1  head entry valid.
- fwd_vec  out  1  head entry targets the vector file.
- fwd_dest  out  DEST_W  head entry destination.
- fwd_data  out  VEC_W  head data; scalar entries are zero-extended.
- retired_cnt  out  32  retired-writes counter (see optional feature).

Behaviour:
- Reset: FIFO empty, pointers and count 0; all outputs 0, including ready_m (gated by rst_n).
- Reset asserted mid-operation discards buffered entries immediately; no write completes.
- Accept:
  - ready_m = rst_n && count != 2, derived from registered count only; no combinational path from rf_ready.
  - Push occurs when valid_m && ready_m at the rising edge.
- Entry capture:
  - vec = (wb_m != 1).
  - data = addervv_m, resALUve_m or memData_m per wb_m; for wb_m = 1 the data is resALUe_m zero-extended to VEC_W.
  - dest = dest_m.
- Head drive:
  - When count > 0: vwe = head.vec, swe = !head.vec, waddr = head.dest, vwdata = head.data, swdata = head.data[SCL_W-1:0].
  - When empty: vwe, swe, waddr and data are all 0.
- Commit: a write completes at an edge where (vwe || swe) && rf_ready; the head is popped at that edge.
- Latency: a bundle accepted at edge N appears on the write port in cycle N+1. Throughput is 1 per cycle while rf_ready stays high.
- Simultaneous push and pop: count unchanged; order strictly FIFO.
- Full (count = 2): ready_m = 0 even if a pop occurs the same cycle.
- Pointers are 1 bit and wrap 1 -> 0.
- Flush: count forced to 0 and pointers reset at the edge.
  - Flush beats push and pop in the same cycle; nothing is written or counted.
- fwd_* mirror the head: fwd_valid = count > 0, fwd_vec = head.vec, fwd_dest = head.dest, fwd_data = head.data. Valid regardless of rf_ready.
- States: EMPTY (count 0), ONE (count 1), FULL (count 2).
  - Transitions: push-only +1, pop-only -1, both or neither hold, flush -> EMPTY.

Optional Feature:
- VEC_WB_RETIRE_CNT_EN defined:
  - retired_cnt increments by 1 on every committed write and wraps 2^32-1 -> 0.
  - Resets to 0; unaffected by flush.
- Undefined: retired_cnt tied to 0 and no counter flops are synthesized.

Test Plan:
- Reset then single bundle (wb_m=2, dest_m=5, resALUve_m=192'hA5..A5, rf_ready=1).
  - Required: next cycle vwe=1, waddr=5, vwdata=A5..A5; following cycle vwe=0, fwd_valid=0.
- Scalar path (wb_m=1, resALUe_m=21'h1FFFFF, dest_m=3).
  - Required: swe=1, vwe=0, swdata=1FFFFF, fwd_data=192'h1FFFFF.
- Backpressure: rf_ready=0 while sending 3 back-to-back bundles with memData values 1,2,3.
  - Required: ready_m drops after 2 accepted; third held.
  - After raising rf_ready, writes appear in order 1,2,3, one per cycle.
- Simultaneous push/pop at count=1 with rf_ready=1 for 4 cycles.
  - Required: count stays 1, ready_m stays 1, writes in order with 1-cycle latency.
- Flush with count=2 and valid_m=1 in the same cycle.
  - Required: next cycle fwd_valid=0, no write, ready_m=1; with VEC_WB_RETIRE_CNT_EN, retired_cnt unchanged.
- Async reset asserted mid-drain (count=2).
  - Required: outputs go 0 immediately without waiting for clk; after release, first write occurs only after a new push.
